// File: rtl/pwm_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel_sequencer
// Brief    : Multi-channel PWM generator with a shared period counter and
//            staged registers that reach the datapath only at period wraps.
//            Build macro PWM_SEQ_IRQ_EN adds CTRL.IRQ_EN and the irq port.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel_sequencer #(
  parameter int NCH   = 7,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [3:0]     address,
  input  logic           chipselect,
  input  logic           write_n,
  input  logic [31:0]    writedata,
  output logic [31:0]    readdata,
  output logic [NCH-1:0] out_port
`ifdef PWM_SEQ_IRQ_EN
  ,
  output logic           irq
`endif
);

  localparam logic [3:0] c_addr_ctrl   = 4'd0;
  localparam logic [3:0] c_addr_status = 4'd1;
  localparam logic [3:0] c_addr_period = 4'd2;
  localparam logic [3:0] c_addr_duty   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 w_wr;
  logic                 w_wr_ctrl;
  logic                 w_wr_status;
  logic                 w_wr_period;
  logic                 w_wr_run;
  logic                 w_wr_stop;
  logic                 w_wr_upd;
  logic                 w_running;
  logic                 w_at_wrap;
  logic                 w_load_start;
  logic                 w_load_upd;
  logic                 w_load;
  logic                 w_wrap_nxt;
  logic                 w_unused;
  logic [NCH-1:0]       w_pwm;
  logic [NCH*CNT_W-1:0] w_duty_stg_flat;

  logic                 r_ctrl_run;
  logic [NCH-1:0]       r_mask_stg;
  logic [NCH-1:0]       r_mask_act;
  logic [CNT_W-1:0]     r_period_stg;
  logic [CNT_W-1:0]     r_period_act;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_upd_pend;
  logic                 r_wrap;
  logic [NCH-1:0]       r_out;

`ifdef PWM_SEQ_IRQ_EN
  logic                 r_irq_en;
  logic                 r_irq;
  logic                 w_irq_en_nxt;
`endif

  assign w_wr         = chipselect & ~write_n;
  assign w_wr_ctrl    = w_wr & (address == c_addr_ctrl);
  assign w_wr_status  = w_wr & (address == c_addr_status);
  assign w_wr_period  = w_wr & (address == c_addr_period);
  assign w_wr_run     = w_wr_ctrl &  writedata[0];
  assign w_wr_stop    = w_wr_ctrl & ~writedata[0];
  assign w_wr_upd     = w_wr_ctrl &  writedata[1];
  assign w_unused     = ^writedata;

  assign w_running    = (r_state != ST_IDLE);
  assign w_at_wrap    = w_running & (r_cnt == r_period_act);
  assign w_load_start = (r_state == ST_IDLE) & w_wr_run;
  assign w_load_upd   = w_at_wrap & r_upd_pend;
  assign w_load       = w_load_start | w_load_upd;

  // A new wrap outranks a simultaneous software clear.
  assign w_wrap_nxt   = w_at_wrap | (r_wrap & ~(w_wr_status & writedata[2]));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_run) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_wr_stop) w_state_nxt = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (w_wr_run)
          w_state_nxt = ST_RUN;
        else if (w_at_wrap)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_duty
    localparam logic [3:0] c_addr = c_addr_duty + 4'(gi);
    logic [CNT_W-1:0] r_duty_stg;
    logic [CNT_W-1:0] r_duty_act;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_duty_stg <= '0;
        r_duty_act <= '0;
      end else begin
        if (w_load) r_duty_act <= r_duty_stg;
        if (w_wr & (address == c_addr)) r_duty_stg <= writedata[CNT_W-1:0];
      end
    end

    assign w_duty_stg_flat[gi*CNT_W +: CNT_W] = r_duty_stg;
    assign w_pwm[gi] = r_mask_act[gi] & (r_cnt < r_duty_act);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ctrl_run   <= 1'b0;
      r_mask_stg   <= '0;
      r_mask_act   <= '0;
      r_period_stg <= '0;
      r_period_act <= '0;
      r_cnt        <= '0;
      r_upd_pend   <= 1'b0;
      r_wrap       <= 1'b0;
      r_out        <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wrap  <= w_wrap_nxt;
      r_out   <= {NCH{w_running}} & w_pwm;

      if (!w_running || w_at_wrap)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);

      // On start the mask arriving with RUN is used, so one CTRL write suffices.
      if (w_load) begin
        r_period_act <= r_period_stg;
        r_mask_act   <= w_load_start ? writedata[8 +: NCH] : r_mask_stg;
      end

      if (w_load_start)
        r_upd_pend <= 1'b0;
      else if (w_wr_upd)
        r_upd_pend <= 1'b1;
      else if (w_load_upd)
        r_upd_pend <= 1'b0;

      if (w_wr_ctrl) begin
        r_ctrl_run <= writedata[0];
        r_mask_stg <= writedata[8 +: NCH];
      end
      if (w_wr_period) r_period_stg <= writedata[CNT_W-1:0];
    end
  end

`ifdef PWM_SEQ_IRQ_EN
  assign w_irq_en_nxt = w_wr_ctrl ? writedata[2] : r_irq_en;

  // Built from next-state values so irq tracks WRAP & IRQ_EN exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_irq_en <= w_irq_en_nxt;
      r_irq    <= w_wrap_nxt & w_irq_en_nxt;
    end
  end

  assign irq = r_irq;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      c_addr_ctrl: begin
        readdata[0]        = r_ctrl_run;
        readdata[8 +: NCH] = r_mask_stg;
`ifdef PWM_SEQ_IRQ_EN
        readdata[2]        = r_irq_en;
`endif
      end
      c_addr_status: readdata[2:0] = {r_wrap, r_upd_pend, w_running};
      c_addr_period: readdata[CNT_W-1:0] = r_period_stg;
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (address == (c_addr_duty + 4'(i)))
            readdata[CNT_W-1:0] = w_duty_stg_flat[i*CNT_W +: CNT_W];
        end
      end
    endcase
  end

  assign out_port = r_out;

endmodule
`default_nettype wire

// File: tb/tb_pwm_channel_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pwm_channel_sequencer
// Brief    : Self-checking bench with a behavioural model of the PWM sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_channel_sequencer;

  localparam int          NCH    = 7;
  localparam int          CNT_W  = 16;
  localparam logic [31:0] CMASK  = 32'h0000_FFFF;
  localparam int          M_IDLE = 0;
  localparam int          M_RUN  = 1;
  localparam int          M_STOP = 2;

  logic           clk;
  logic           reset_n;
  logic [3:0]     address;
  logic           chipselect;
  logic           write_n;
  logic [31:0]    writedata;
  logic [31:0]    readdata;
  logic [NCH-1:0] out_port;
`ifdef PWM_SEQ_IRQ_EN
  logic           irq;
`endif

  pwm_channel_sequencer #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
`ifdef PWM_SEQ_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int             m_mode;
  logic [31:0]    m_cnt, m_per_s, m_per_a;
  logic [31:0]    m_duty_s [NCH];
  logic [31:0]    m_duty_a [NCH];
  logic [NCH-1:0] m_mask_s, m_mask_a, m_out;
  logic           m_runbit, m_pend, m_wrap, m_irq_en, m_irq;

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_per_s = 0; m_per_a = 0;
    m_mask_s = '0; m_mask_a = '0; m_out = '0;
    m_runbit = 0; m_pend = 0; m_wrap = 0; m_irq_en = 0; m_irq = 0;
    for (int c = 0; c < NCH; c++) begin m_duty_s[c] = 0; m_duty_a[c] = 0; end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r = 32'h0;
    if (a == 4'd0) begin
      r[0] = m_runbit; r[2] = m_irq_en; r[8 +: NCH] = m_mask_s;
    end else if (a == 4'd1) begin
      r[2:0] = {m_wrap, m_pend, m_mode != M_IDLE};
    end else if (a == 4'd2) begin
      r = m_per_s;
    end else if (a >= 4'd8 && int'(a) < 8 + NCH) begin
      r = m_duty_s[a - 4'd8];
    end
    return r;
  endfunction

  // One clock: derive the next model state from the bus inputs, then advance.
  task automatic tick();
    logic [3:0]     a;
    logic [31:0]    d, ncnt;
    logic           wr, running, wrapc, runw, stopw, updw, start, load;
    logic           npend, nwrap, nirq_en;
    logic [NCH-1:0] nout;
    int             nmode;
    a = address; d = writedata; wr = chipselect && !write_n;
    running = (m_mode != M_IDLE);
    wrapc   = running && (m_cnt == m_per_a);
    runw    = wr && a == 4'd0 && d[0];
    stopw   = wr && a == 4'd0 && !d[0];
    updw    = wr && a == 4'd0 && d[1];
    start   = (m_mode == M_IDLE) && runw;
    load    = start || (wrapc && m_pend);
    for (int c = 0; c < NCH; c++)
      nout[c] = running && m_mask_a[c] && (m_cnt < m_duty_a[c]);
    nmode = m_mode;
    if (m_mode == M_IDLE && runw) nmode = M_RUN;
    else if (m_mode == M_RUN && stopw) nmode = M_STOP;
    else if (m_mode == M_STOP) nmode = runw ? M_RUN : (wrapc ? M_IDLE : M_STOP);
    ncnt  = (running && !wrapc) ? m_cnt + 1 : 0;
    npend = start ? 1'b0 : updw ? 1'b1 : (wrapc && m_pend) ? 1'b0 : m_pend;
    nwrap = wrapc ? 1'b1 : (wr && a == 4'd1 && d[2]) ? 1'b0 : m_wrap;
`ifdef PWM_SEQ_IRQ_EN
    nirq_en = (wr && a == 4'd0) ? d[2] : m_irq_en;
`else
    nirq_en = 1'b0;
`endif
    @(posedge clk);
    if (load) begin
      m_per_a  = m_per_s;
      m_mask_a = start ? d[8 +: NCH] : m_mask_s;
      for (int c = 0; c < NCH; c++) m_duty_a[c] = m_duty_s[c];
    end
    if (wr) begin
      if (a == 4'd0) begin m_runbit = d[0]; m_mask_s = d[8 +: NCH]; end
      if (a == 4'd2) m_per_s = d & CMASK;
      if (a >= 4'd8 && int'(a) < 8 + NCH) m_duty_s[a - 4'd8] = d & CMASK;
    end
    m_mode = nmode; m_cnt = ncnt; m_pend = npend; m_wrap = nwrap;
    m_irq_en = nirq_en; m_irq = nwrap && nirq_en; m_out = nout;
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata;
  endtask

  task automatic wait_cnt(input logic [31:0] target);
    int i;
    for (i = 0; i < 40 && !(m_mode != M_IDLE && m_cnt == target); i++) tick();
    if (!(m_mode != M_IDLE && m_cnt == target)) begin
      n_checks++; n_errors++;
      $display("FAIL wait_cnt: got cnt %0d expected %0d", m_cnt, target);
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40 && m_mode != M_IDLE; i++) tick();
    if (m_mode != M_IDLE) begin
      n_checks++; n_errors++;
      $display("FAIL wait_idle: got mode %0d expected %0d", m_mode, M_IDLE);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n = 1'b0; model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    n_checks++;
    if (out_port !== '0) begin
      n_errors++; $display("FAIL reset_out: got %h expected %h", out_port, 7'h0);
    end
    for (int a = 0; a < 16; a++) begin
      rd(a[3:0], v);
      n_checks++;
      if (v !== 32'h0) begin
        n_errors++; $display("FAIL reset_reg[%0d]: got %h expected %h", a, v, 32'h0);
      end
      tick();
    end
  endtask

  task automatic test_basic_pwm();
    int hi;
    bus_write(4'd2, 32'd9);
    bus_write(4'd8, 32'd3);
    bus_write(4'd9, 32'd10);
    bus_write(4'd10, 32'd0);
    bus_write(4'd0, 32'h700);
    bus_write(4'd0, 32'h701);
    n_checks++;
    if (out_port !== 7'h00) begin
      n_errors++; $display("FAIL basic_first: got %h expected %h", out_port, 7'h00);
    end
    tick();
    n_checks++;
    if (out_port !== 7'h03) begin
      n_errors++; $display("FAIL basic_start: got %h expected %h", out_port, 7'h03);
    end
    hi = int'(out_port[0]);
    for (int i = 0; i < 29; i++) begin
      tick();
      if (i < 9) hi += int'(out_port[0]);
      n_checks++;
      if (out_port !== m_out) begin
        n_errors++; $display("FAIL basic_cycle: got %h expected %h", out_port, m_out);
      end
    end
    n_checks++;
    if (hi != 3) begin
      n_errors++; $display("FAIL basic_duty0: got %0d high cycles expected 3", hi);
    end
  endtask

  task automatic test_boundary_update();
    logic [31:0] v;
    int hi_old, hi_new;
    bus_write(4'd8, 32'd7);
    if (m_cnt == m_per_a) tick();
    bus_write(4'd0, 32'h703);
    rd(4'd1, v);
    n_checks++;
    if (v[1] !== 1'b1) begin
      n_errors++; $display("FAIL upd_pend_set: got %b expected 1", v[1]);
    end
    for (int i = 0; i < 22; i++) begin
      tick();
      n_checks++;
      if (out_port !== m_out) begin
        n_errors++; $display("FAIL upd_cycle: got %h expected %h", out_port, m_out);
      end
    end
    rd(4'd1, v);
    n_checks++;
    if (v[1] !== 1'b0) begin
      n_errors++; $display("FAIL upd_pend_clear: got %b expected 0", v[1]);
    end
    bus_write(4'd8, 32'd2);
    wait_cnt(32'd9);
    bus_write(4'd0, 32'h703);
    hi_old = 0; hi_new = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 9 || i == 10) begin
        rd(4'd1, v);
        n_checks++;
        if (v[1] !== (i == 9)) begin
          n_errors++; $display("FAIL wrapupd_pend[%0d]: got %b expected %b", i, v[1], i == 9);
        end
      end
      if (i <= 10) hi_old += int'(out_port[0]); else hi_new += int'(out_port[0]);
      n_checks++;
      if (out_port !== m_out) begin
        n_errors++; $display("FAIL wrapupd_cycle: got %h expected %h", out_port, m_out);
      end
    end
    n_checks++;
    if (hi_old != 7 || hi_new != 2) begin
      n_errors++; $display("FAIL wrapupd_duty: got %0d/%0d expected 7/2", hi_old, hi_new);
    end
  endtask

  task automatic test_graceful_stop();
    logic [31:0] v;
    wait_cnt(32'd4);
    bus_write(4'd0, 32'h700);
    rd(4'd1, v);
    n_checks++;
    if (v[0] !== 1'b1) begin
      n_errors++; $display("FAIL stop_running: got %b expected 1", v[0]);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out_port !== m_out) begin
        n_errors++; $display("FAIL stop_cycle: got %h expected %h", out_port, m_out);
      end
    end
    rd(4'd1, v);
    n_checks++;
    if (v !== 32'h4) begin
      n_errors++; $display("FAIL stop_status: got %h expected %h", v, 32'h4);
    end
    tick();
    n_checks++;
    if (out_port !== 7'h00) begin
      n_errors++; $display("FAIL stop_out: got %h expected %h", out_port, 7'h00);
    end
    bus_write(4'd0, 32'h701);
    wait_cnt(32'd2);
    bus_write(4'd0, 32'h700);
    wait_cnt(32'd6);
    bus_write(4'd0, 32'h701);
    for (int i = 0; i < 25; i++) begin
      tick();
      n_checks++;
      if (out_port !== m_out) begin
        n_errors++; $display("FAIL resume_cycle: got %h expected %h", out_port, m_out);
      end
    end
    rd(4'd1, v);
    n_checks++;
    if (v[0] !== 1'b1) begin
      n_errors++; $display("FAIL resume_running: got %b expected 1", v[0]);
    end
  endtask

  task automatic test_wrap_w1c();
    logic [31:0] v;
    if (m_cnt == m_per_a) tick();
    bus_write(4'd1, 32'h4);
    rd(4'd1, v);
    n_checks++;
    if (v[2] !== 1'b0) begin
      n_errors++; $display("FAIL w1c_clear: got %b expected 0", v[2]);
    end
    wait_cnt(32'd9);
    bus_write(4'd1, 32'h4);
    rd(4'd1, v);
    n_checks++;
    if (v[2] !== 1'b1) begin
      n_errors++; $display("FAIL w1c_setwins: got %b expected 1", v[2]);
    end
`ifdef PWM_SEQ_IRQ_EN
    bus_write(4'd0, 32'h705);
    n_checks++;
    if (irq !== 1'b1) begin
      n_errors++; $display("FAIL irq_on: got %b expected 1", irq);
    end
    bus_write(4'd0, 32'h701);
    n_checks++;
    if (irq !== 1'b0) begin
      n_errors++; $display("FAIL irq_off: got %b expected 0", irq);
    end
`endif
  endtask

  task automatic test_p0();
    logic [31:0] v;
    bus_write(4'd0, 32'h700);
    wait_idle();
    bus_write(4'd2, 32'd0);
    bus_write(4'd8, 32'd1);
    bus_write(4'd9, 32'd0);
    bus_write(4'd0, 32'h701);
    tick();
    for (int i = 0; i < 8; i++) begin
      bus_write(4'd1, 32'h4);
      n_checks++;
      if (out_port !== 7'h01) begin
        n_errors++; $display("FAIL p0_out: got %h expected %h", out_port, 7'h01);
      end
      rd(4'd1, v);
      n_checks++;
      if (v[2] !== 1'b1) begin
        n_errors++; $display("FAIL p0_wrap: got %b expected 1", v[2]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int          idx;
      logic [3:0]  a;
      logic [31:0] d;
      idx = int'($urandom_range(0, 11));
      a = (idx < 3) ? 4'(idx) : (idx < 10) ? 4'(idx + 5) : (idx == 10) ? 4'd3 : 4'd15;
      if (a == 4'd0)
        d = ($urandom & 32'h0000_FF04) | (($urandom_range(0, 9) < 8) ? 32'h1 : 32'h0)
          | (($urandom_range(0, 5) == 0) ? 32'h2 : 32'h0);
      else if (a == 4'd2)
        d = $urandom_range(0, 12);
      else if (a >= 4'd8)
        d = $urandom_range(0, 14);
      else
        d = $urandom;
      address = a; writedata = d;
      chipselect = ($urandom_range(0, 3) == 0);
      write_n = $urandom_range(0, 1) == 1;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
      n_checks++;
      if (out_port !== m_out) begin
        n_errors++; $display("FAIL rand_out[%0d]: got %h expected %h", i, out_port, m_out);
      end
      n_checks++;
      if (readdata !== model_read(address)) begin
        n_errors++;
        $display("FAIL rand_read[%0d] addr %0d: got %h expected %h", i, address, readdata, model_read(address));
      end
`ifdef PWM_SEQ_IRQ_EN
      n_checks++;
      if (irq !== m_irq) begin
        n_errors++; $display("FAIL rand_irq[%0d]: got %b expected %b", i, irq, m_irq);
      end
`endif
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] v;
    bus_write(4'd2, 32'd9);
    bus_write(4'd8, 32'd5);
    bus_write(4'd0, 32'h103);
    for (int i = 0; i < 60 && !m_out[0]; i++) tick();
    if (!m_out[0]) begin
      n_checks++; n_errors++; $display("FAIL midrun_wait: got %b expected 1", m_out[0]);
    end
    n_checks++;
    if (out_port !== m_out) begin
      n_errors++; $display("FAIL midrun_pre: got %h expected %h", out_port, m_out);
    end
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_port !== 7'h00) begin
      n_errors++; $display("FAIL midrun_async: got %h expected %h", out_port, 7'h00);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int a = 0; a < 3; a++) begin
      rd(a[3:0], v);
      n_checks++;
      if (v !== 32'h0) begin
        n_errors++; $display("FAIL midrun_reg[%0d]: got %h expected %h", a, v, 32'h0);
      end
      tick();
    end
    rd(4'd8, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_errors++; $display("FAIL midrun_duty0: got %h expected %h", v, 32'h0);
    end
    repeat (3) tick();
    n_checks++;
    if (out_port !== 7'h00) begin
      n_errors++; $display("FAIL midrun_idle: got %h expected %h", out_port, 7'h00);
    end
  endtask

  initial begin
    reset_n = 1'b0; address = 4'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    model_reset();
    test_reset();
    test_basic_pwm();
    test_boundary_update();
    test_graceful_stop();
    test_wrap_w1c();
    test_p0();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
